// File: rtl/ai_wb_sequencer.sv
// ai_wb_sequencer: streams layer weight/bias words from memory to the datapath, one word per read/capture/offer cycle.
// Ports: clk, rst (async, active-high); start/abort control a pass; busy/done report it;
// mem_ren/mem_addr/mem_rdata read memory (data one cycle after ren);
// wb_valid/wb_ready handshake wb_data/wb_layer/wb_index; stall_cnt counts stalled offer cycles.
// Optional: define AI_WB_SEQ_STALL_CNT_EN to build the stall counter; otherwise stall_cnt is tied to 0.
module ai_wb_sequencer #(
  parameter int L0_LEN = 64,
  parameter int L1_LEN = 512,
  parameter int L2_LEN = 512,
  parameter int L3_LEN = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [3:0]        wb_data,
  output logic [1:0]        wb_layer,
  output logic [9:0]        wb_index,
  output logic [15:0]       stall_cnt
);
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, CAPT = 3'd2, OUT = 3'd3, DONE = 3'd4;
  function automatic int len(input int l);
    return l == 0 ? L0_LEN : l == 1 ? L1_LEN : l == 2 ? L2_LEN : L3_LEN;
  endfunction
  // First layer at or after l with a nonzero length; 4 means none remain.
  function automatic int next_nz(input int l);
    int r;
    r = 4;
    for (int i = 3; i >= 0; i--) if (i >= l && len(i) != 0) r = i;
    return r;
  endfunction
  localparam int FIRST = next_nz(0);
  logic [2:0] state;
  logic [1:0] layer;
  logic [9:0] index;
  logic [ADDR_W-1:0] addr;
  logic last_idx;
  int nxt;
  assign nxt = next_nz(int'(layer) + 1);
  assign last_idx = int'(index) == len(int'(layer)) - 1;
  assign busy = state == READ || state == CAPT || state == OUT;
  assign done = state == DONE;
  assign mem_ren = state == READ;
  assign wb_valid = state == OUT;
  assign mem_addr = addr;
  assign wb_layer = layer;
  assign wb_index = index;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      layer <= '0;
      index <= '0;
      addr <= '0;
      wb_data <= '0;
    end else if (state != IDLE && abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= FIRST == 4 ? DONE : READ;
          layer <= 2'(FIRST);
          index <= '0;
          addr <= '0;
        end
        READ: state <= CAPT;
        CAPT: begin
          wb_data <= mem_rdata;
          state <= OUT;
        end
        OUT: if (wb_ready) begin
          addr <= addr + 1'b1;
          index <= last_idx ? '0 : index + 1'b1;
          layer <= last_idx ? 2'(nxt) : layer;
          state <= last_idx && nxt == 4 ? DONE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AI_WB_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (state == IDLE && start) stall_cnt <= '0;
    else if (wb_valid && !wb_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ai_wb_sequencer.sv
// tb_ai_wb_sequencer: randomized self-checking bench for ai_wb_sequencer against a word-list reference model.
module tb_ai_wb_sequencer;
  logic clk = 0, rst = 0, start = 0, abort = 0, ready = 1, sel = 0;
  always #5 clk = ~clk;
`ifdef AI_WB_SEQ_STALL_CNT_EN
  localparam bit SC = 1;
`else
  localparam bit SC = 0;
`endif
  logic busy_a, done_a, ren_a, valid_a, busy_b, done_b, ren_b, valid_b;
  logic [11:0] addr_a, addr_b;
  logic [3:0] rd_a, rd_b, data_a, data_b;
  logic [1:0] layer_a, layer_b;
  logic [9:0] index_a, index_b;
  logic [15:0] stall_a, stall_b;
  ai_wb_sequencer dut_a (
    .clk(clk), .rst(rst), .start(start && !sel), .abort(abort && !sel),
    .busy(busy_a), .done(done_a), .mem_ren(ren_a), .mem_addr(addr_a), .mem_rdata(rd_a),
    .wb_valid(valid_a), .wb_ready(ready), .wb_data(data_a), .wb_layer(layer_a),
    .wb_index(index_a), .stall_cnt(stall_a)
  );
  ai_wb_sequencer #(.L1_LEN(0)) dut_b (
    .clk(clk), .rst(rst), .start(start && sel), .abort(abort && sel),
    .busy(busy_b), .done(done_b), .mem_ren(ren_b), .mem_addr(addr_b), .mem_rdata(rd_b),
    .wb_valid(valid_b), .wb_ready(ready), .wb_data(data_b), .wb_layer(layer_b),
    .wb_index(index_b), .stall_cnt(stall_b)
  );
  logic busy, done, mem_ren, wb_valid;
  logic [11:0] mem_addr;
  logic [3:0] wb_data;
  logic [1:0] wb_layer;
  logic [9:0] wb_index;
  logic [15:0] stall_cnt;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign mem_ren = sel ? ren_b : ren_a;
  assign wb_valid = sel ? valid_b : valid_a;
  assign mem_addr = sel ? addr_b : addr_a;
  assign wb_data = sel ? data_b : data_a;
  assign wb_layer = sel ? layer_b : layer_a;
  assign wb_index = sel ? index_b : index_a;
  assign stall_cnt = sel ? stall_b : stall_a;
  function automatic logic [3:0] mdat(input logic [11:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8];
  endfunction
  always @(posedge clk) begin
    rd_a <= mdat(addr_a);
    rd_b <= mdat(addr_b);
  end
  typedef struct {int layer; int index; int addr;} word_t;
  word_t exp_q[$];
  int lens[4];
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, req);
    end
  endtask
  task automatic build();
    int a = 0;
    exp_q.delete();
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < lens[l]; i++) begin
        exp_q.push_back('{l, i, a});
        a++;
      end
  endtask
  task automatic set_dut(input bit s);
    sel = s;
    lens = s ? '{64, 0, 512, 16} : '{64, 512, 512, 16};
    build();
  endtask
  // mode 0: ready held 1; mode 1: random ready; mode 2: stall on word 100 then abort
  task automatic run_pass(input int mode);
    int k = 0, busy_cycles = 0, stalls = 0, nd;
    bit prev_stall = 0, got_done = 0;
    logic [16:0] saved = '0;
    int n = exp_q.size();
    start = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (done) begin
        check("done_busy", busy, 0);
        got_done = 1;
        break;
      end
      if (busy) busy_cycles++;
      if (mem_ren) check("mem_addr", mem_addr, exp_q[k].addr);
      if (prev_stall) check("stall_hold", {wb_valid, wb_data, wb_layer, wb_index}, saved);
      if (mode == 2 && k == 100 && wb_valid) begin
        ready = 0;
        repeat (10) @(negedge clk);
        check("stall_valid", wb_valid, 1);
        check("stall_data", wb_data, mdat(12'(exp_q[k].addr)));
        check("stall_cnt10", stall_cnt, SC ? 10 : 0);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_out", {wb_valid, busy, mem_ren}, 0);
        nd = 0;
        repeat (5) begin
          if (done || busy) nd++;
          @(negedge clk);
        end
        check("abort_idle", nd, 0);
        ready = 1;
        return;
      end
      ready = mode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
      if (wb_valid && ready) begin
        check("wb_layer", wb_layer, exp_q[k].layer);
        check("wb_index", wb_index, exp_q[k].index);
        check("wb_data", wb_data, mdat(12'(exp_q[k].addr)));
        k++;
      end
      if (wb_valid && !ready) stalls++;
      prev_stall = wb_valid && !ready;
      saved = {wb_valid, wb_data, wb_layer, wb_index};
      @(negedge clk);
    end
    if (!got_done) begin
      check("timeout", 0, 1);
      return;
    end
    @(negedge clk);
    check("done_pulse", {done, busy}, 0);
    check("word_count", k, n);
    if (mode == 0) check("busy_cycles", busy_cycles, 3 * n);
    check("stall_cnt", stall_cnt, SC ? stalls : 0);
  endtask
  task automatic reset_mid_pass();
    int r = 0;
    bit hit = 0;
    ready = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (mem_ren) r++;
      if (r == 5) begin
        hit = 1;
        rst = 1;
        #1;
        check("rst_ctl", {busy, done, mem_ren, wb_valid}, 0);
        check("rst_dat", {mem_addr, wb_data, wb_layer, wb_index, stall_cnt}, 0);
        break;
      end
      @(negedge clk);
    end
    if (!hit) check("rst_timeout", 0, 1);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    check("rst_idle", {busy, mem_ren, wb_valid, done}, 0);
  endtask
  initial begin
    #2 rst = 1;
    #1;
    check("reset_ctl", {busy, done, mem_ren, wb_valid}, 0);
    check("reset_dat", {mem_addr, wb_data, wb_layer, wb_index, stall_cnt}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("idle_wait", busy, 0);
    set_dut(0);
    run_pass(0);
    run_pass(1);
    run_pass(2);
    run_pass(1);
    reset_mid_pass();
    run_pass(1);
    set_dut(1);
    run_pass(1);
    run_pass(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
